pe_tail_acc: RTL and testbench

Parametrised last-column processing element of the systolic array and successor to the single-buffer tail PE. Each cycle it multiplies a streamed activation by a stationary weight and adds the upstream partial sum. In GEMM mode it accumulates over a K-length tile into one of NBANK ping-pong accumulator banks. Completed results drain through a valid/ready output port, so draining one tile overlaps computing the next. In CNN/DNN stream modes every beat is a complete result.

---
 rtl/pe_tail_acc_pkg.sv | 39 +++
 rtl/pe_tail_acc_if.sv | 39 +++
 rtl/pe_tail_acc_mac.sv | 47 ++++
 rtl/pe_tail_acc.sv | 119 +++++++++++
 tb/tb_pe_tail_acc.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_tail_acc_pkg.sv
// pe_pkg: mode encoding and the width-generic saturating add
// shared by the tail PE and its MAC datapath.
package pe_pkg;

  typedef logic [1:0] pe_mode_t;

  localparam pe_mode_t MODE_GEMM = 2'b00;
  localparam pe_mode_t MODE_CNN  = 2'b01;
  localparam pe_mode_t MODE_DNN  = 2'b10;
  localparam pe_mode_t MODE_HOLD = 2'b11;

  localparam int SAT_W = 64;

  typedef struct packed {
    logic             hit;
    logic [SAT_W-1:0] val;
  } sat_res_t;

  // Operands are sign-extended ACCW-bit values; clamp to ACCW range.
  function automatic sat_res_t sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      accw
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] s;
    sat_res_t                r;
    hi = (64'sd1 <<< (accw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    s  = a + b;
    r.hit = (s > hi) || (s < lo);
    if (s > hi)      r.val = hi;
    else if (s < lo) r.val = lo;
    else             r.val = s;
    return r;
  endfunction

endpackage

// File: rtl/pe_tail_acc_if.sv
// Handshake and control bundle of the tail PE; master drives
// beats and control, slave is the PE.
interface pe_tail_acc_if
  import pe_pkg::*;
#(
  parameter int DW   = 8,
  parameter int ACCW = 20
);
  logic                   clr;
  pe_mode_t               mode;
  logic                   w_load;
  logic signed [DW-1:0]   w_in;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  logic signed [DW-1:0]   data_in;
  logic signed [ACCW-1:0] psum_in;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [ACCW-1:0] out_data;
  logic                   ovf;
  logic                   busy;

  modport master (
    output clr, mode, w_load, w_in,
    output in_valid, in_last, data_in, psum_in,
    output out_ready,
    input  in_ready, out_valid, out_data,
    input  ovf, busy
  );

  modport slave (
    input  clr, mode, w_load, w_in,
    input  in_valid, in_last, data_in, psum_in,
    input  out_ready,
    output in_ready, out_valid, out_data,
    output ovf, busy
  );
endinterface

// File: rtl/pe_tail_acc_mac.sv
// pe_tail_mac: combinational data*weight + psum + base.
// PE_TAIL_SAT_EN selects saturating adds, else two's-complement wrap.
module pe_tail_mac
  import pe_pkg::*;
#(
  parameter int DW   = 8,
  parameter int ACCW = 20
) (
  input  logic signed [DW-1:0]   i_data,
  input  logic signed [DW-1:0]   i_weight,
  input  logic signed [ACCW-1:0] i_psum,
  input  logic signed [ACCW-1:0] i_base,
  output logic signed [ACCW-1:0] o_sum,
  output logic                   o_sat_hit
);

  logic signed [2*DW-1:0] w_dx;
  logic signed [2*DW-1:0] w_wx;
  logic signed [2*DW-1:0] w_prod;
  logic signed [ACCW-1:0] w_prod_x;

  assign w_dx     = {{DW{i_data[DW-1]}}, i_data};
  assign w_wx     = {{DW{i_weight[DW-1]}}, i_weight};
  assign w_prod   = w_dx * w_wx;
  assign w_prod_x = {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};

`ifdef PE_TAIL_SAT_EN
  sat_res_t w_t;
  sat_res_t w_s;
  logic     w_fit_err;

  assign w_t = sat_add(SAT_W'(w_prod_x), SAT_W'(i_psum), ACCW);
  assign w_s = sat_add(w_t.val, SAT_W'(i_base), ACCW);
  // Clamped result always fits; upper bits must mirror the sign.
  assign w_fit_err = (w_s.val[SAT_W-1:ACCW-1] !=
                      {(SAT_W-ACCW+1){w_s.val[ACCW-1]}});
  assign o_sum     = w_s.val[ACCW-1:0];
  assign o_sat_hit = w_t.hit | w_s.hit | w_fit_err;
`else
  logic signed [ACCW-1:0] w_term;

  assign w_term    = w_prod_x + i_psum;
  assign o_sum     = w_term + i_base;
  assign o_sat_hit = 1'b0;
`endif

endmodule

// File: rtl/pe_tail_acc.sv
// pe_tail_acc: last-column PE with NBANK ping-pong accumulators
// and a valid/ready drain port. Optional macro: PE_TAIL_SAT_EN.
module pe_tail_acc
  import pe_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACCW  = 20,
  parameter int NBANK = 2
) (
  input logic          clk,
  input logic          rst,
  pe_tail_acc_if.slave bus
);

  localparam int PW = $clog2(NBANK);

  logic signed [ACCW-1:0] r_acc [NBANK];
  logic [NBANK-1:0]       r_full;
  logic [PW-1:0]          r_wr;
  logic [PW-1:0]          r_rd;
  logic signed [DW-1:0]   r_weight;
  pe_mode_t               r_mode;
  logic                   r_in_tile;
  logic                   r_out_valid;
  logic signed [ACCW-1:0] r_out_data;
  logic                   r_ovf;

  pe_mode_t               w_mode;
  logic                   w_stream;
  logic                   w_accept;
  logic                   w_close;
  logic                   w_drain;
  logic signed [ACCW-1:0] w_base;
  logic signed [ACCW-1:0] w_sum;
  logic                   w_sat_hit;

  // Mode is frozen for the rest of a GEMM tile once it has started.
  assign w_mode   = r_in_tile ? r_mode : bus.mode;
  assign w_stream = (w_mode == MODE_CNN) ||
                    (w_mode == MODE_DNN);

  assign bus.in_ready = !rst && !bus.clr &&
                        !r_full[r_wr] &&
                        (w_mode != MODE_HOLD);

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_close  = w_stream || bus.in_last;
  assign w_base   = r_in_tile ? r_acc[r_wr] : '0;
  assign w_drain  = r_full[r_rd] && !bus.clr &&
                    (!r_out_valid || bus.out_ready);

  pe_tail_mac #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .i_data    (bus.data_in),
    .i_weight  (r_weight),
    .i_psum    (bus.psum_in),
    .i_base    (w_base),
    .o_sum     (w_sum),
    .o_sat_hit (w_sat_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBANK; i++) r_acc[i] <= '0;
      r_full      <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_weight    <= '0;
      r_mode      <= MODE_GEMM;
      r_in_tile   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (bus.w_load) r_weight <= bus.w_in;
      if (bus.clr) begin
        for (int i = 0; i < NBANK; i++) r_acc[i] <= '0;
        r_full      <= '0;
        r_wr        <= '0;
        r_rd        <= '0;
        r_mode      <= MODE_GEMM;
        r_in_tile   <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_ovf       <= 1'b0;
      end else begin
        if (w_accept) begin
          r_acc[r_wr] <= w_sum;
          if (!r_in_tile) r_mode <= bus.mode;
          if (w_sat_hit)  r_ovf  <= 1'b1;
          if (w_close) begin
            r_full[r_wr] <= 1'b1;
            r_wr         <= r_wr + PW'(1);
            r_in_tile    <= 1'b0;
          end else begin
            r_in_tile    <= 1'b1;
          end
        end
        // Write and drain never share a bank: drain only reads full ones.
        if (w_drain) begin
          r_out_data   <= r_acc[r_rd];
          r_out_valid  <= 1'b1;
          r_full[r_rd] <= 1'b0;
          r_rd         <= r_rd + PW'(1);
        end else if (bus.out_ready) begin
          r_out_valid  <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.ovf       = r_ovf;
  assign bus.busy      = (|r_full) || r_out_valid;

endmodule

// File: tb/tb_pe_tail_acc.sv
// Directed + randomized bench for pe_tail_acc against a tile-level
// arithmetic model; honours PE_TAIL_SAT_EN for the expected values.
module tb_pe_tail_acc;
  import pe_pkg::*;

  localparam int DW    = 8;
  localparam int ACCW  = 20;
  localparam int NBANK = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_tail_acc_if #(.DW(DW), .ACCW(ACCW)) bus ();

  pe_tail_acc #(
    .DW    (DW),
    .ACCW  (ACCW),
    .NBANK (NBANK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic rescue = 1'b0;
  logic m_ovf  = 1'b0;
  longint m_w  = 0;

  logic signed [ACCW-1:0] got[$];
  int                     got_cyc[$];
  logic signed [ACCW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst && !bus.clr && bus.out_valid && bus.out_ready) begin
      got.push_back(bus.out_data);
      got_cyc.push_back(cyc);
    end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic longint fitw(input longint x);
    longint lim = longint'(1) <<< (ACCW - 1);
`ifdef PE_TAIL_SAT_EN
    if (x > lim - 1) begin m_ovf = 1'b1; return lim - 1; end
    if (x < -lim)    begin m_ovf = 1'b1; return -lim;    end
    return x;
`else
    longint m = x % (2 * lim);
    if (m < 0)    m += 2 * lim;
    if (m >= lim) m -= 2 * lim;
    return m;
`endif
  endfunction

  function automatic logic signed [ACCW-1:0] tile_res(
    input longint w, input longint d[$], input longint p[$]);
    longint acc = 0;
    foreach (d[i]) acc = fitw(acc + fitw(d[i] * w + p[i]));
    return ACCW'(acc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag,
                      input logic signed [ACCW-1:0] obs,
                      input logic signed [ACCW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic load_w(input int w);
    idle();
    bus.w_load = 1'b1;
    bus.w_in   = DW'(w);
    tick();
    bus.w_load = 1'b0;
    m_w = w;
  endtask

  task automatic send(input logic signed [DW-1:0] d,
                      input logic signed [ACCW-1:0] p,
                      input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.psum_in  = p;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      if (rescue) bus.out_ready = 1'b1;
      n++;
      @(negedge clk);
    end
    chk1("beat_accept", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag);
    chkn({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chkv($sformatf("%s_out%0d", tag, i), got[i], exp_q[i]);
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    idle();
    bus.out_ready = 1'b1;
    tick();
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    tick();
    chk1({tag, "_idle"}, bus.busy, 1'b0);
    chk_outs(tag);
  endtask

  longint    dq[$];
  longint    pq[$];
  longint    rd;
  longint    rp;
  int        k;
  int        span;
  logic      gemm;
  logic      lst;
  pe_mode_t  bm;

  initial begin
    rst           = 1'b1;
    bus.clr       = 1'b0;
    bus.mode      = MODE_GEMM;
    bus.w_load    = 1'b0;
    bus.w_in      = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.data_in   = '0;
    bus.psum_in   = '0;
    bus.out_ready = 1'b0;

    // reset values
    @(negedge clk);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chkv("rst_out_data", bus.out_data, '0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_ovf", bus.ovf, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_in_ready", bus.in_ready, 1'b1);

    // GEMM tile of 4: 4*(3*2+1) = 28, with latency check
    load_w(3);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(2, 1, i == 3);
    idle();
    @(negedge clk);
    chk1("lat_e0_valid", bus.out_valid, 1'b0);
    chk1("lat_e0_busy", bus.busy, 1'b1);
    tick();
    @(negedge clk);
    chk1("lat_e1_valid", bus.out_valid, 1'b1);
    chkv("lat_e1_data", bus.out_data, 20'sd28);
    exp_q.push_back(28);
    drain("gemm28");

    // three back-to-back tiles with the output stalled
    bus.out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      dq.delete();
      pq.delete();
      for (int b = 0; b < 3; b++) begin
        rd = longint'($urandom_range(0, 255)) - 128;
        rp = longint'($urandom_range(0, 4095)) - 2048;
        dq.push_back(rd);
        pq.push_back(rp);
        send(DW'(rd), ACCW'(rp), b == 2);
      end
      exp_q.push_back(tile_res(m_w, dq, pq));
    end
    idle();
    @(negedge clk);
    chk1("all_full_in_ready", bus.in_ready, 1'b0);
    tick();
    tick();
    @(negedge clk);
    chk1("stall_valid", bus.out_valid, 1'b1);
    chkv("stall_hold_data", bus.out_data, exp_q[0]);
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    span = (got_cyc.size() >= 3) ? got_cyc[2] - got_cyc[0] : -1;
    chkn("pingpong_rate", span, 2);
    drain("pingpong");

    // DNN stream: weight -4, data 1..5
    load_w(-4);
    bus.mode = MODE_DNN;
    for (int i = 1; i <= 5; i++) begin
      send(DW'(i), '0, 1'b0);
      exp_q.push_back(ACCW'(-4 * i));
    end
    idle();
    for (int i = 0; i < 5; i++) tick();
    span = (got_cyc.size() >= 5) ? got_cyc[4] - got_cyc[0] : -1;
    chkn("dnn_rate", span, 4);
    drain("dnn");

    // weight load coincident with a beat uses the old weight
    bus.mode = MODE_CNN;
    load_w(3);
    bus.w_load = 1'b1;
    bus.w_in   = 8'sd5;
    send(1, '0, 1'b0);
    bus.w_load = 1'b0;
    m_w = 5;
    send(1, '0, 1'b0);
    exp_q.push_back(3);
    exp_q.push_back(5);
    drain("wload");

    // hold mode blocks input
    bus.mode     = MODE_HOLD;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk1("hold_in_ready", bus.in_ready, 1'b0);
    idle();
    tick();

    // randomized tiles, random back-pressure, mid-tile mode changes
    rescue = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0)
        load_w(int'($urandom_range(0, 255)) - 128);
      gemm = ($urandom_range(0, 2) != 0);
      k    = gemm ? int'($urandom_range(1, 4)) : 1;
      dq.delete();
      pq.delete();
      for (int b = 0; b < k; b++) begin
        rd = longint'($urandom_range(0, 255)) - 128;
        rp = longint'($urandom_range(0, 32767)) - 16384;
        if (gemm) begin
          bm  = (b == 0) ? MODE_GEMM
                         : pe_mode_t'($urandom_range(0, 2));
          lst = (b == k - 1);
        end else begin
          bm  = pe_mode_t'($urandom_range(1, 2));
          lst = 1'($urandom_range(0, 1));
        end
        bus.mode      = bm;
        bus.out_ready = 1'($urandom_range(0, 1));
        dq.push_back(rd);
        pq.push_back(rp);
        send(DW'(rd), ACCW'(rp), lst);
      end
      exp_q.push_back(tile_res(m_w, dq, pq));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        tick();
      end
    end
    rescue = 1'b0;
    drain("random");

    // overflow tile: weight 127, data 127, psum 2^19-1
    bus.clr = 1'b1;
    tick();
    bus.clr  = 1'b0;
    m_ovf    = 1'b0;
    bus.mode = MODE_GEMM;
    load_w(127);
    bus.out_ready = 1'b1;
    dq.delete();
    pq.delete();
    for (int b = 0; b < 2; b++) begin
      dq.push_back(127);
      pq.push_back((longint'(1) <<< (ACCW - 1)) - 1);
      send(8'sd127, ACCW'((longint'(1) <<< (ACCW - 1)) - 1), b == 1);
    end
    exp_q.push_back(tile_res(m_w, dq, pq));
    drain("sat");
    chk1("sat_ovf", bus.ovf, m_ovf);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk1("ovf_clr", bus.ovf, 1'b0);

    // clr mid-tile with a pending result
    load_w(3);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2, 1, i == 3);
    send(2, 1, 1'b0);
    bus.clr = 1'b1;
    @(negedge clk);
    chk1("clr_in_ready", bus.in_ready, 1'b0);
    tick();
    bus.clr = 1'b0;
    idle();
    @(negedge clk);
    chk1("clr_out_valid", bus.out_valid, 1'b0);
    chk1("clr_busy", bus.busy, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    drain("clr_empty");
    for (int i = 0; i < 4; i++) send(2, 1, i == 3);
    exp_q.push_back(28);
    drain("post_clr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
